parallax_layer_gen: RTL and testbench



---
 rtl/parallax_layer_if.sv | 25 ++
 rtl/parallax_layer_gen.sv | 151 +++++++++++++++
 tb/tb_parallax_layer_gen.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/parallax_layer_if.sv
// Sync-generator strobes into the skyline generator and per-layer pixel flags out to the palette.
interface parallax_layer_if #(
    parameter int NUM_LAYERS = 4
);
    localparam int TL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    logic                  visible;
    logic                  line_end;
    logic                  frame_end;
    logic                  scroll_en;
    logic [NUM_LAYERS-1:0] hit;
    logic [TL_W-1:0]       top_layer;
    logic                  any_hit;
    logic                  edge_pix;

    modport master (
        output visible, line_end, frame_end, scroll_en,
        input  hit, top_layer, any_hit, edge_pix
    );

    modport slave (
        input  visible, line_end, frame_end, scroll_en,
        output hit, top_layer, any_hit, edge_pix
    );
endinterface

// File: rtl/parallax_layer_gen.sv
// N-layer parallax skyline generator: per-layer LFSR column heights against a rising row cutoff.
// Define PARALLAX_EDGE_EN to build the layer-0 outline output (edge_pix); otherwise it is tied low.
module parallax_layer_gen #(
    parameter int                NUM_LAYERS = 4,
    parameter int                LFSR_W     = 9,
    parameter logic [LFSR_W-1:0] TAPS       = 9'h110,
    parameter int                HBITS      = 4,
    parameter int                COLW_LOG2  = 4,
    parameter int                ROWH_LOG2  = 4,
    parameter int                TOP_ROW    = 112,
    parameter int                ROW_OFF    = 64
) (
    input logic             clk,
    input logic             rst_n,
    parallax_layer_if.slave bus
);
    localparam int TL_W   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int LINE_W = 10;
    localparam logic [HBITS:0] CUT_MAX = {1'b1, {HBITS{1'b0}}};

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & TAPS)};
    endfunction

    logic [LINE_W-1:0]     line_cnt;
    logic [LINE_W-1:0]     line_nx;
    logic [NUM_LAYERS-1:0] hit_nx;
    logic [TL_W-1:0]       top_nx;
    logic                  edge_nx;
`ifdef PARALLAX_EDGE_EN
    logic                  col0_lt2;
`endif

    assign line_nx = line_cnt + 1'b1;

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
        localparam int CW = COLW_LOG2 - i;
        localparam int RH = ROWH_LOG2 - i;
        localparam logic [LINE_W-1:0] START     = LINE_W'(TOP_ROW + i * ROW_OFF);
        localparam logic [LINE_W-1:0] STEP_MASK = LINE_W'((1 << RH) - 1);

        logic [LFSR_W-1:0] lfsr;
        logic [LFSR_W-1:0] base;
        logic [CW-1:0]     col_cnt;
        logic [CW-1:0]     col_base;
        logic [HBITS:0]    cutoff;
        logic [LINE_W-1:0] row_ofs;
        logic              row_hit;
        logic              div_wrap;

        // cutoff is advanced at the line_end that enters the next line, so it is ready for its first pixel
        assign row_ofs   = line_nx - START;
        assign row_hit   = (line_nx >= START) && ((row_ofs & STEP_MASK) == '0);
        assign hit_nx[i] = bus.visible && ({1'b0, lfsr[HBITS-1:0]} < cutoff);

`ifdef PARALLAX_EDGE_EN
        if (i == 0) begin : g_col0
            assign col0_lt2 = ({1'b0, col_cnt} < (CW+1)'(2));
        end
`endif

        if (i == 0) begin : g_div
            assign div_wrap = 1'b1;
        end else begin : g_div
            logic [i-1:0] div;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    div <= '0;
                end else if (bus.frame_end && bus.scroll_en) begin
                    div <= div + 1'b1;
                end
            end
            assign div_wrap = &div;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                lfsr     <= '1;
                base     <= '1;
                col_cnt  <= '1;
                col_base <= '1;
                cutoff   <= '0;
            end else begin
                if (bus.line_end) begin
                    lfsr    <= base;
                    col_cnt <= col_base;
                end else if (bus.visible) begin
                    col_cnt <= col_cnt + 1'b1;
                    if (col_cnt == '0) begin
                        lfsr <= lfsr_step(lfsr);
                    end
                end

                if (bus.frame_end) begin
                    cutoff <= '0;
                    if (bus.scroll_en && div_wrap) begin
                        col_base <= col_base + 1'b1;
                        if (col_base == '0) begin
                            base <= lfsr_step(base);
                        end
                    end
                end else if (bus.line_end && row_hit && (cutoff != CUT_MAX)) begin
                    cutoff <= cutoff + 1'b1;
                end
            end
        end
    end

    always_comb begin
        top_nx = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (hit_nx[i]) begin
                top_nx = TL_W'(i);
            end
        end
    end

`ifdef PARALLAX_EDGE_EN
    localparam logic [LINE_W-1:0] START0 = LINE_W'(TOP_ROW);
    localparam logic [LINE_W-1:0] MASK0  = LINE_W'((1 << ROWH_LOG2) - 1);
    logic [LINE_W-1:0] row0_pos;
    logic              row0_border;

    // hit_nx[0] already implies the line is inside the layer-0 ramp, so the wrap below start is harmless
    assign row0_pos    = (line_cnt - START0) & MASK0;
    assign row0_border = (row0_pos == '0) || (row0_pos == MASK0);
    assign edge_nx     = hit_nx[0] && (col0_lt2 || row0_border);
`else
    assign edge_nx = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_cnt      <= '0;
            bus.hit       <= '0;
            bus.top_layer <= '0;
            bus.any_hit   <= 1'b0;
            bus.edge_pix  <= 1'b0;
        end else begin
            if (bus.frame_end) begin
                line_cnt <= '0;
            end else if (bus.line_end) begin
                line_cnt <= line_nx;
            end
            bus.hit       <= hit_nx;
            bus.top_layer <= top_nx;
            bus.any_hit   <= |hit_nx;
            bus.edge_pix  <= edge_nx;
        end
    end
endmodule

// File: tb/tb_parallax_layer_gen.sv
// Randomized frames against a closed-form skyline model (column/scroll/ramp arithmetic), checked every cycle.
`timescale 1ns/1ps
module tb_parallax_layer_gen;
    localparam int NL    = 4;
    localparam int LINES = 370;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    parallax_layer_if #(.NUM_LAYERS(NL)) bus();
    parallax_layer_gen #(.NUM_LAYERS(NL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;

    int         frames;
    int         line_no;
    int         px;
    int         line_cb  [NL];
    logic [8:0] cur_lfsr [NL];
    int         cur_n    [NL];

    logic [NL-1:0] exp_hit  = '0;
    logic [1:0]    exp_top  = '0;
    logic          exp_any  = 1'b0;
    logic          exp_edge = 1'b0;
    bit            exp_valid = 1'b0;

    function automatic logic [8:0] lstep(input logic [8:0] v);
        return {v[7:0], ^(v & 9'h110)};
    endfunction

    function automatic int colw(input int i);
        return 1 << (4 - i);
    endfunction

    function automatic int cut_of(input int i, input int l);
        int start = 112 + 64 * i;
        int k;
        if (l < start) return 0;
        k = (l - start) / (1 << (4 - i)) + 1;
        return (k > 16) ? 16 : k;
    endfunction

    // LFSR steps taken during the first x visible pixels of a line starting at column phase cb
    function automatic int nsteps(input int cb, input int c, input int x);
        int j0 = (c - cb) % c;
        if (x <= j0) return 0;
        return (x - 1 - j0) / c + 1;
    endfunction

    function automatic int cb_of(input int i, input int f);
        return (colw(i) - 1 + (f >> i)) % colw(i);
    endfunction

    function automatic int bsteps_of(input int i, input int f);
        int a = f >> i;
        return (a >= 2) ? (a - 2) / colw(i) + 1 : 0;
    endfunction

    function automatic logic [8:0] base_of(input int i, input int f);
        logic [8:0] v = 9'h1FF;
        for (int k = 0; k < bsteps_of(i, f); k++) v = lstep(v);
        return v;
    endfunction

    task automatic pin(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        frames  = 0;
        line_no = 0;
        px      = 0;
        for (int i = 0; i < NL; i++) begin
            line_cb[i]  = colw(i) - 1;
            cur_lfsr[i] = 9'h1FF;
            cur_n[i]    = 0;
        end
    endtask

    task automatic cyc(input bit vis, input bit le, input bit fe, input bit se, input bit rst);
        logic [NL-1:0] h;
        int tl;
        bit e;
        rst_n         = !rst;
        bus.visible   = vis;
        bus.line_end  = le;
        bus.frame_end = fe;
        bus.scroll_en = se;
        h = '0;
        if (!rst) begin
            for (int i = 0; i < NL; i++) begin
                int need = nsteps(line_cb[i], colw(i), px);
                while (cur_n[i] < need) begin
                    cur_lfsr[i] = lstep(cur_lfsr[i]);
                    cur_n[i]++;
                end
                h[i] = vis && (int'(cur_lfsr[i][3:0]) < cut_of(i, line_no));
            end
        end
        tl = 0;
        for (int i = NL - 1; i >= 0; i--) if (h[i]) tl = i;
        e = 1'b0;
`ifdef PARALLAX_EDGE_EN
        if (h[0]) begin
            int colpos = (line_cb[0] + px) % 16;
            int rowpos = (line_no - 112) % 16;
            e = (colpos < 2) || (rowpos == 0) || (rowpos == 15);
        end
`endif
        if (rst) begin
            model_reset();
        end else begin
            if (le) begin
                px = 0;
                for (int i = 0; i < NL; i++) begin
                    line_cb[i]  = cb_of(i, frames);
                    cur_lfsr[i] = base_of(i, frames);
                    cur_n[i]    = 0;
                end
            end else if (vis) begin
                px++;
            end
            if (fe) line_no = 0;
            else if (le) line_no++;
            if (fe && se) frames++;
        end
        @(posedge clk);
        #1;
        exp_hit   = h;
        exp_top   = tl[1:0];
        exp_any   = |h;
        exp_edge  = e;
        exp_valid = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_valid) begin
            total += 4;
            if (bus.hit !== exp_hit) begin
                bad++;
                $display("FAIL hit t=%0t: got %b expected %b", $time, bus.hit, exp_hit);
            end
            if (bus.top_layer !== exp_top) begin
                bad++;
                $display("FAIL top_layer t=%0t: got %0d expected %0d", $time, bus.top_layer, exp_top);
            end
            if (bus.any_hit !== exp_any) begin
                bad++;
                $display("FAIL any_hit t=%0t: got %b expected %b", $time, bus.any_hit, exp_any);
            end
            if (bus.edge_pix !== exp_edge) begin
                bad++;
                $display("FAIL edge t=%0t: got %b expected %b", $time, bus.edge_pix, exp_edge);
            end
        end
    end

    initial begin
        bit scroll_pat [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

        pin("cut0_111", cut_of(0, 111), 0);
        pin("cut0_112", cut_of(0, 112), 1);
        pin("cut0_128", cut_of(0, 128), 2);
        pin("cut0_352", cut_of(0, 352), 16);
        pin("cut0_500", cut_of(0, 500), 16);
        pin("cut1_175", cut_of(1, 175), 0);
        pin("cut1_176", cut_of(1, 176), 1);
        pin("cut1_184", cut_of(1, 184), 2);
        pin("steps0_640", nsteps(15, 16, 640), 40);
        pin("steps3_640", nsteps(1, 2, 640), 320);
        pin("cb0_f2", cb_of(0, 2), 1);
        pin("cb1_f2", cb_of(1, 2), 0);
        pin("bsteps0_f2", bsteps_of(0, 2), 1);
        pin("lstep_1ff", int'(lstep(9'h1FF)), 9'h1FE);

        model_reset();
        bus.visible   = 1'b0;
        bus.line_end  = 1'b0;
        bus.frame_end = 1'b0;
        bus.scroll_en = 1'b0;

        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        repeat (640) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        for (int f = 0; f < 4; f++) begin
            bit se = scroll_pat[f];
            for (int ln = 0; ln < LINES; ln++) begin
                int len = (ln == 200) ? 640 : 16 + int'($urandom % 40);
                for (int p = 0; p < len; p++) begin
                    cyc(($urandom % 8) != 0, 1'b0, 1'b0, se, 1'b0);
                end
                cyc(1'b0, 1'b0, 1'b0, se, 1'b0);
                cyc(bit'($urandom % 2), 1'b1, ln == LINES - 1, se, 1'b0);
                if (f == 3 && ln == 250) begin
                    repeat (3) cyc(1'b1, 1'b0, 1'b0, se, 1'b1);
                end
            end
        end

        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_valid = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
